// File: rtl/motion_indicator_decoder_pkg.sv
// Shared motion-digit encodings and ring helpers used by the decoder and
// the motion indicator FSM.
package motion_indicator_decoder_pkg;

  typedef enum logic [2:0] {
    MODE_STOP = 3'd0,
    MODE_R1X  = 3'd1,
    MODE_R2X  = 3'd2,
    MODE_L1X  = 3'd3,
    MODE_L2X  = 3'd4,
    MODE_FWD  = 3'd5,
    MODE_REV  = 3'd6
  } mode_e;

  typedef enum logic [2:0] {
    XN_NEUTRAL,
    XN_MOVE,
    XN_STOP,
    XN_ILLEGAL,
    XN_JUMP
  } xition_e;

  localparam logic [4:0] SEG_A     = 5'd16;
  localparam logic [4:0] SEG_B     = 5'd17;
  localparam logic [4:0] SEG_C     = 5'd18;
  localparam logic [4:0] SEG_D     = 5'd19;
  localparam logic [4:0] SEG_E     = 5'd20;
  localparam logic [4:0] SEG_F     = 5'd21;
  localparam logic [4:0] SEG_G     = 5'd22;
  localparam logic [4:0] SEG_BLANK = 5'd23;

  function automatic logic is_ring(input logic [4:0] c);
    return (c >= SEG_A) && (c <= SEG_F);
  endfunction

  function automatic logic [4:0] ring_next(input logic [4:0] c);
    return (c == SEG_F) ? SEG_A : c + 5'd1;
  endfunction

  function automatic logic [4:0] ring_prev(input logic [4:0] c);
    return (c == SEG_A) ? SEG_F : c - 5'd1;
  endfunction

endpackage

// File: rtl/motion_indicator_decoder_if.sv
// Code stream in, decoded motion status out.
interface motion_indicator_decoder_if;
  logic [4:0] seg_code;
  logic [2:0] motion_mode;
  logic       mode_valid;
  logic       mode_change;
  logic       err;

  modport master (
    output seg_code,
    input  motion_mode, mode_valid, mode_change, err
  );

  modport slave (
    input  seg_code,
    output motion_mode, mode_valid, mode_change, err
  );
endinterface

// File: rtl/motion_indicator_decoder_seg_interval_timer.sv
// Cycles since the last code change, saturating at TIMEOUT, with a single
// timeout pulse per stall.
module seg_interval_timer #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 60_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_ivl,
  output logic             o_sat,
  output logic             o_timeout_pulse
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_ivl;
  logic             r_fired;

  assign o_ivl           = r_ivl;
  assign o_sat           = (r_ivl == TMO);
  // A change in the same cycle wins over the timeout.
  assign o_timeout_pulse = o_sat && !r_fired && !i_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ivl   <= '0;
      r_fired <= 1'b0;
    end else if (i_clear) begin
      r_ivl   <= '0;
      r_fired <= 1'b0;
    end else begin
      if (!o_sat)          r_ivl   <= r_ivl + 1'b1;
      if (o_timeout_pulse) r_fired <= 1'b1;
    end
  end

endmodule

// File: rtl/motion_indicator_decoder.sv
// Recovers the rojobot motion mode from the seven-segment code stream that
// drives the motion digit.
module motion_indicator_decoder
  import motion_indicator_decoder_pkg::*;
#(
  parameter int SPEED_THRESH = 15_000_000,
  parameter int TIMEOUT      = 60_000_000,
  parameter int CONFIRM      = 2,
  parameter int CNT_W        = 27
) (
  input logic                        clk,
  input logic                        reset,
  motion_indicator_decoder_if.slave  io_bus
);

  localparam logic [2:0]       CONF  = 3'(CONFIRM);
  localparam logic [CNT_W-1:0] SPEED = CNT_W'(SPEED_THRESH);

  logic [4:0]       r_cur_q;
  mode_e            r_cand;
  logic [2:0]       r_agree;
  mode_e            r_mode;
  logic             r_valid;
  logic             r_change;
  logic             r_err;

  logic             w_change;
  logic [CNT_W-1:0] w_ivl;
  logic             w_sat;
  logic             w_tmo_pulse;
  logic             w_timeout;
  logic             w_fast;
  xition_e          w_kind;
  mode_e            w_cls;
  mode_e            w_cand_nx;
  logic [2:0]       w_agree_nx;
  mode_e            w_mode_nx;
  logic             w_valid_nx;
  logic             w_err_nx;
  logic             w_chg_nx;

  assign w_change  = (io_bus.seg_code != r_cur_q);
  assign w_timeout = w_sat && w_tmo_pulse;
  assign w_fast    = (w_ivl < SPEED);

  seg_interval_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .i_clear         (w_change),
    .o_ivl           (w_ivl),
    .o_sat           (w_sat),
    .o_timeout_pulse (w_tmo_pulse)
  );

  // Classify the transition p=r_cur_q -> n=seg_code.
  always_comb begin
    w_kind = XN_NEUTRAL;
    w_cls  = MODE_STOP;
    if ((io_bus.seg_code < SEG_A) || (io_bus.seg_code > SEG_BLANK)) begin
      w_kind = XN_ILLEGAL;
    end else if (io_bus.seg_code == SEG_G) begin
      w_kind = XN_STOP;
    end else if (is_ring(r_cur_q) && is_ring(io_bus.seg_code)) begin
      if (io_bus.seg_code == ring_next(r_cur_q)) begin
        w_kind = XN_MOVE;
        w_cls  = w_fast ? MODE_R2X : MODE_R1X;
      end else if (io_bus.seg_code == ring_prev(r_cur_q)) begin
        w_kind = XN_MOVE;
        w_cls  = w_fast ? MODE_L2X : MODE_L1X;
      end else begin
        w_kind = XN_JUMP;
      end
    end else if (((r_cur_q == SEG_A) && (io_bus.seg_code == SEG_BLANK)) ||
                 ((r_cur_q == SEG_BLANK) && (io_bus.seg_code == SEG_A))) begin
      w_kind = XN_MOVE;
      w_cls  = MODE_FWD;
    end else if (((r_cur_q == SEG_D) && (io_bus.seg_code == SEG_BLANK)) ||
                 ((r_cur_q == SEG_BLANK) && (io_bus.seg_code == SEG_D))) begin
      w_kind = XN_MOVE;
      w_cls  = MODE_REV;
    end
  end

  // Confirmation, stop bypass and stall handling.
  always_comb begin
    w_cand_nx  = r_cand;
    w_agree_nx = r_agree;
    w_mode_nx  = r_mode;
    w_valid_nx = r_valid;
    w_err_nx   = 1'b0;
    if (w_change) begin
      case (w_kind)
        XN_ILLEGAL: begin
          w_err_nx   = 1'b1;
          w_valid_nx = 1'b0;
          w_agree_nx = '0;
        end
        XN_JUMP: begin
          w_err_nx   = 1'b1;
          w_agree_nx = '0;
        end
        XN_STOP: begin
          w_mode_nx  = MODE_STOP;
          w_valid_nx = 1'b1;
          w_agree_nx = '0;
        end
        XN_MOVE: begin
          if (w_cls == r_cand) begin
            w_agree_nx = (r_agree >= CONF) ? CONF : r_agree + 3'd1;
          end else begin
            w_cand_nx  = w_cls;
            w_agree_nx = 3'd1;
          end
          if (w_agree_nx == CONF) begin
            w_mode_nx  = w_cand_nx;
            w_valid_nx = 1'b1;
          end
        end
        default: w_agree_nx = '0;
      endcase
    end else if (w_timeout) begin
      if (r_cur_q == SEG_G) begin
        w_mode_nx  = MODE_STOP;
        w_valid_nx = 1'b1;
      end else begin
        w_valid_nx = 1'b0;
      end
    end
    w_chg_nx = (w_mode_nx != r_mode) || (w_valid_nx && !r_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_q  <= SEG_BLANK;
      r_cand   <= MODE_STOP;
      r_agree  <= '0;
      r_mode   <= MODE_STOP;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cur_q  <= io_bus.seg_code;
      r_cand   <= w_cand_nx;
      r_agree  <= w_agree_nx;
      r_mode   <= w_mode_nx;
      r_valid  <= w_valid_nx;
      r_change <= w_chg_nx;
      r_err    <= w_err_nx;
    end
  end

  assign io_bus.motion_mode = r_mode;
  assign io_bus.mode_valid  = r_valid;
  assign io_bus.mode_change = r_change;
  assign io_bus.err         = r_err;

endmodule

// File: tb/tb_motion_indicator_decoder.sv
// Scoreboard bench: a transition-rule model predicts every cycle's outputs,
// a monitor compares them against the decoder.
module tb_motion_indicator_decoder;
  localparam int ST = 4;
  localparam int TO = 20;
  localparam int CF = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motion_indicator_decoder_if bus ();

  motion_indicator_decoder #(
    .SPEED_THRESH (ST),
    .TIMEOUT      (TO),
    .CONFIRM      (CF),
    .CNT_W        (27)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic       valid;
    logic       chg;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_cur, m_cnt, m_cand, m_agree, m_mode;
  bit m_fired, m_valid;

  function automatic int ring_idx(input int c);
    return (c >= 16 && c <= 21) ? c - 16 : -1;
  endfunction

  // -1 neutral, -2 illegal code, -3 ring jump, 100 stop, else mode 1..6
  function automatic int classify(input int p, input int n, input int gap);
    int ip, in_, d;
    ip  = ring_idx(p);
    in_ = ring_idx(n);
    if (n < 16 || n > 23) return -2;
    if (n == 22) return 100;
    if (ip >= 0 && in_ >= 0) begin
      d = (in_ - ip + 6) % 6;
      if (d == 1) return (gap < ST) ? 2 : 1;
      if (d == 5) return (gap < ST) ? 4 : 3;
      return -3;
    end
    if ((p == 16 && n == 23) || (p == 23 && n == 16)) return 5;
    if ((p == 19 && n == 23) || (p == 23 && n == 19)) return 6;
    return -1;
  endfunction

  task automatic model_step(input bit rst, input int n);
    exp_t e;
    int   nm, cls;
    bit   nv, er;
    if (rst) begin
      m_cur = 23; m_cnt = 0; m_fired = 0; m_cand = 0; m_agree = 0;
      m_mode = 0; m_valid = 0;
      q.push_back('0);
      return;
    end
    nm = m_mode; nv = m_valid; er = 0;
    if (n != m_cur) begin
      cls = classify(m_cur, n, m_cnt);
      if (cls == -2) begin
        er = 1; nv = 0; m_agree = 0;
      end else if (cls == -3) begin
        er = 1; m_agree = 0;
      end else if (cls == -1) begin
        m_agree = 0;
      end else if (cls == 100) begin
        nm = 0; nv = 1; m_agree = 0;
      end else begin
        if (cls == m_cand) m_agree = (m_agree < CF) ? m_agree + 1 : CF;
        else begin
          m_cand  = cls;
          m_agree = 1;
        end
        if (m_agree == CF) begin
          nm = m_cand; nv = 1;
        end
      end
      m_cnt = 0; m_fired = 0;
    end else if (m_cnt == TO) begin
      if (!m_fired) begin
        m_fired = 1;
        if (m_cur == 22) begin
          nm = 0; nv = 1;
        end else nv = 0;
      end
    end else begin
      m_cnt++;
    end
    m_cur   = n;
    e.mode  = 3'(nm);
    e.valid = nv;
    e.chg   = (nm != m_mode) || (nv && !m_valid);
    e.err   = er;
    m_mode  = nm;
    m_valid = nv;
    q.push_back(e);
  endtask

  task automatic drive(input bit rst, input int n);
    @(negedge clk);
    #1;
    reset        = rst;
    bus.seg_code = 5'(n);
    model_step(rst, n);
  endtask

  task automatic hold(input int n, input int k);
    repeat (k) drive(1'b0, n);
  endtask

  task automatic check(input string name, input int em, input bit ev);
    n_tests++;
    if (bus.motion_mode !== 3'(em) || bus.mode_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d valid=%0b, expected mode=%0d valid=%0b",
               name, bus.motion_mode, bus.mode_valid, em, ev);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_tests++;
        if ({bus.motion_mode, bus.mode_valid, bus.mode_change, bus.err} !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got mode=%0d valid=%0b chg=%0b err=%0b, expected mode=%0d valid=%0b chg=%0b err=%0b",
                   $time, bus.motion_mode, bus.mode_valid, bus.mode_change, bus.err,
                   e.mode, e.valid, e.chg, e.err);
        end
      end
    end
  end

  initial begin
    int cur, r, n, k, idx;
    reset        = 1'b1;
    bus.seg_code = 5'd23;
    repeat (3) drive(1'b1, 23);
    check("reset", 0, 0);

    hold(16, 8); hold(17, 8); hold(18, 8); hold(19, 8);
    check("r1x", 1, 1);
    hold(22, 25);
    check("stop_hold", 0, 1);
    hold(16, 2); hold(21, 2); hold(20, 2);
    check("l2x_wrap", 4, 1);
    repeat (2) begin
      hold(16, 10); hold(23, 10);
    end
    check("fwd", 5, 1);
    hold(19, 10); hold(23, 10);
    check("rev", 6, 1);
    hold(16, 3); hold(18, 3);
    check("jump_hold", 6, 1);
    hold(3, 3);
    check("illegal_invalid", 6, 0);
    hold(17, 3); hold(18, 3); hold(19, 3);
    check("r2x", 2, 1);
    hold(19, 23);
    check("stall_invalid", 2, 0);
    drive(1'b0, 20); drive(1'b1, 21); drive(1'b1, 16);
    check("reset_mid", 0, 0);
    hold(16, 3);

    cur = 16;
    for (int s = 0; s < 250; s++) begin
      r   = $urandom_range(0, 99);
      k   = $urandom_range(1, 24);
      idx = ring_idx(cur);
      if (r < 2) begin
        drive(1'b1, cur); drive(1'b1, cur);
        continue;
      end else if (r < 45) begin
        if (idx >= 0) n = 16 + ((idx + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6);
        else          n = $urandom_range(16, 21);
      end else if (r < 60) n = 23;
      else if (r < 72)     n = ($urandom_range(0, 1) == 1) ? 16 : 19;
      else if (r < 82)     n = 22;
      else if (r < 87)     n = $urandom_range(0, 15);
      else                 n = $urandom_range(0, 31);
      hold(n, k);
      cur = n;
    end
    hold(cur, 2);

    @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
